// File: rtl/dot_acc.sv
// Streaming signed multiply-accumulate: one rounded, shifted, saturated result per frame of (x, y) pairs.
// Latency: z_valid rises the cycle after the final pair of a frame is accepted.
// Backpressure: a held result (z_valid && !z_ready) freezes z, acc and count and drops x_ready.
module dot_acc #(
    parameter int WIDTH     = 8,
    parameter int LENGTH    = 16,
    parameter int SHIFT     = 0,
    parameter int ACC_WIDTH = 20
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic signed [WIDTH-1:0] x,
    input  logic signed [WIDTH-1:0] y,
    input  logic                    x_last,
    input  logic                    x_valid,
    output logic                    x_ready,
    output logic signed [WIDTH-1:0] z,
    output logic                    z_valid,
    input  logic                    z_ready
);

    localparam int CNT_W = (LENGTH > 1) ? $clog2(LENGTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LENGTH - 1);

    localparam logic signed [ACC_WIDTH:0] SAT_MAX =
        {{(ACC_WIDTH - WIDTH + 2){1'b0}}, {(WIDTH - 1){1'b1}}};
    localparam logic signed [ACC_WIDTH:0] SAT_MIN =
        {{(ACC_WIDTH - WIDTH + 2){1'b1}}, {(WIDTH - 1){1'b0}}};

    logic signed [ACC_WIDTH-1:0] acc;
    logic        [CNT_W-1:0]     count;

    logic signed [2*WIDTH-1:0]   p;
    logic signed [ACC_WIDTH-1:0] p_ext;
    logic signed [ACC_WIDTH-1:0] s;
    logic signed [ACC_WIDTH:0]   s_wide;
    logic signed [ACC_WIDTH:0]   r;
    logic signed [WIDTH-1:0]     z_next;
    logic                        acc_in;
    logic                        out_fire;
    logic                        frame_end;

    assign x_ready   = reset && (!z_valid || z_ready);
    assign acc_in    = x_valid && x_ready;
    assign out_fire  = z_valid && z_ready;
    assign frame_end = acc_in && (x_last || (count == CNT_LAST));

    assign p      = x * y;
    assign p_ext  = ACC_WIDTH'(p);
    // acc is already zero at the start of every frame, so a same-cycle turnover needs no special case
    assign s      = acc + p_ext;
    assign s_wide = (ACC_WIDTH + 1)'(s);

    generate
        if (SHIFT == 0) begin : g_no_round
            assign r = s_wide;
        end else begin : g_round
            localparam logic signed [ACC_WIDTH:0] RND_ADD = (ACC_WIDTH + 1)'(1) << (SHIFT - 1);
            assign r = (s_wide + RND_ADD) >>> SHIFT;
        end
    endgenerate

    always_comb begin
        z_next = r[WIDTH-1:0];
        if (r > SAT_MAX) begin
            z_next = SAT_MAX[WIDTH-1:0];
        end else if (r < SAT_MIN) begin
            z_next = SAT_MIN[WIDTH-1:0];
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            acc     <= '0;
            count   <= '0;
            z       <= '0;
            z_valid <= 1'b0;
        end else begin
            if (out_fire) begin
                z_valid <= 1'b0;
            end
            if (frame_end) begin
                acc     <= '0;
                count   <= '0;
                z       <= z_next;
                z_valid <= 1'b1;
            end else if (acc_in) begin
                acc   <= s;
                count <= count + CNT_W'(1);
            end
        end
    end

endmodule

// File: doc/dot_acc.md
Name: dot_acc

Overview:
- Streaming signed multiply-accumulate stage that sits directly upstream of the clip operator.
- Accepts a stream of (x, y) operand pairs and accumulates their products over a frame of up to LENGTH pairs.
- Emits one rounded, shifted and saturated WIDTH-bit result per frame.
- Uses a valid/ready handshake on both sides; the result feeds the clip stage's x input.

Parameters:
- WIDTH, 8: signed bit width of x, y and z.
- LENGTH, 16: maximum number of pairs per frame (≥1).
- SHIFT, 0: arithmetic right shift applied to the final sum (0 ≤ SHIFT < ACC_WIDTH).
- ACC_WIDTH, 20: accumulator width; must be ≥ 2*WIDTH + clog2(LENGTH).

Ports:
- clock, input, 1: sole clock; all state updates on posedge.
- reset, input, 1: synchronous, active-low; reset is applied when reset==0 at a posedge.
- x, input, WIDTH: signed operand A.
- y, input, WIDTH: signed operand B.
- x_last, input, 1: marks the final pair of a frame (early termination).
- x_valid, input, 1: operand pair valid.
- x_ready, output, 1: block can accept a pair.
- z, output, WIDTH: signed frame result.
- z_valid, output, 1: result valid.
- z_ready, input, 1: downstream accepts the result.

Behaviour:
- Reset (reset==0 at posedge): acc=0, count=0, z=0, z_valid=0. x_ready is forced to 0 while reset==0. Reset mid-frame discards the partial sum and any pending result.
- Accept event: acc_in = x_valid && x_ready.
- Output event: out_fire = z_valid && z_ready.
- x_ready = reset && (!z_valid || z_ready). This is combinational and allows zero-bubble frame turnover.
- Product: p = signed x * signed y, full 2*WIDTH bits, sign-extended to ACC_WIDTH.
- On acc_in, not last: acc <= acc + p; count <= count + 1.
- Frame ends on acc_in when x_last==1 OR count==LENGTH-1, whichever comes first.
- At frame end: s = acc + p; acc <= 0; count <= 0; z_valid <= 1; z <= sat(rnd(s)).
- rnd(s): if SHIFT==0, s. Otherwise (s + 2^(SHIFT-1)) >>> SHIFT, computed in ACC_WIDTH+1 bits (round half toward +inf).
- sat(v): clamp v to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
- Latency: z_valid rises in the cycle after the final accept.
- While z_valid==1 && z_ready==0: z and z_valid hold stable; x_ready==0; acc and count unchanged.
- out_fire without a simultaneous frame end: z_valid <= 0; z retains its last value.
- out_fire in the same cycle as a pair accept that is not a frame end: the new frame starts with acc = p, count = 1.
- out_fire in the same cycle as an accept that is a frame end (x_last on the first pair, or LENGTH==1): z_valid stays 1 and z takes the new result.
- x_last is ignored when x_valid==0.
- Overflow of acc cannot occur under the ACC_WIDTH constraint; no wrap handling is required.
- State: the FSM is implicit. ACCUM (z_valid==0, or z_valid with z_ready) vs HOLD (z_valid && !z_ready). No other states.

Test Plan:
1. Basic frame: WIDTH=8, LENGTH=4, SHIFT=0, x=1,2,3,4, y=2, z_ready=1 → single z_valid pulse, z=20, one cycle after the 4th accept.
2. Saturation: x=127, y=127 ×4 → z=127. Then x=-128, y=127 ×4 → z=-128.
3. Early termination: x=3, y=-5 on two pairs, x_last on the 2nd → z=-30. The next frame starts from acc=0.
4. Rounding: SHIFT=2. Frame sum 10 → z=3. Frame sum -10 → z=-2. Frame sum 6 → z=2.
5. Backpressure: hold z_ready=0 for 5 cycles after a result. Required: x_ready=0, z and z_valid constant throughout. Raise z_ready together with x_valid → handshake and new accept occur in the same cycle, with no bubble.
6. Reset mid-frame: after 2 accepts, drive reset=0 for 1 cycle → z_valid=0, z=0. Next frame 1,1,1,1 × y=1 → z=4, showing no residue from the aborted frame.
